// File: rtl/gpio_bank_mmio_if.sv
`timescale 1ns/1ps
// gpio_bank_mmio_if: core-bus slave port of the GPIO bank.
// Latency: none; this file only bundles wires.
// Backpressure: none. The bus has no ready signal, so every access completes in one cycle.
// Signals:
//   sel       - bank select from the memory controller
//   Address   - byte address; the bank decodes word offset Address[4:2]
//   WriteData - write data
//   MemWrite  - write strobe
//   ReadData  - combinational read data
interface gpio_bank_mmio_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  sel;
  logic [DATA_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] ReadData;

  modport master (
    output sel, Address, WriteData, MemWrite,
    input  ReadData
  );

  modport slave (
    input  sel, Address, WriteData, MemWrite,
    output ReadData
  );
endinterface

// File: rtl/gpio_bank_mmio.sv
`timescale 1ns/1ps
// gpio_bank_mmio: memory-mapped GPIO bank. It provides per-bit direction, atomic set/clear/toggle,
//   an input synchroniser, sticky rising-edge capture and a masked interrupt.
// Latency: reads are combinational, writes take effect at the next clk edge, pin to IN takes
//   SYNC_STAGES edges, EDGE sets one edge later, and irq follows EDGE/MASK by one edge.
// Backpressure: none. Every access completes in a single cycle.
// Ports:
//   clk, reset     - core clock; asynchronous active-high reset
//   bus            - gpio_bank_mmio_if.slave (sel/Address/WriteData/MemWrite/ReadData)
//   gpio_port_in   - asynchronous pin inputs
//   gpio_port_out  - OUT & DIR
//   gpio_oe        - DIR
//   irq            - registered |(EDGE & MASK)
// Optional feature: define GPIO_DEBOUNCE_EN to insert a DB_CYCLES per-bit debounce filter
//   between the synchroniser and IN.
// Register map (word offset Address[4:2]):
//   0 OUT rw, 1 IN ro, 2 DIR rw, 3 EDGE w1c, 4 MASK rw, 5 SET wo, 6 CLR wo, 7 TGL wo
module gpio_bank_mmio #(
  parameter int DATA_WIDTH  = 32,
  parameter int GPIO_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  gpio_bank_mmio_if.slave       bus,
  input  logic [GPIO_WIDTH-1:0] gpio_port_in,
  output logic [GPIO_WIDTH-1:0] gpio_port_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_IN   = 3'd1;
  localparam logic [2:0] A_DIR  = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_MASK = 3'd4;
  localparam logic [2:0] A_SET  = 3'd5;
  localparam logic [2:0] A_CLR  = 3'd6;
  localparam logic [2:0] A_TGL  = 3'd7;

  logic                  wr_en;
  logic [2:0]            word_addr;
  logic [GPIO_WIDTH-1:0] wd;

  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q, sync_d;
  logic [GPIO_WIDTH-1:0] out_q,  out_d;
  logic [GPIO_WIDTH-1:0] dir_q,  dir_d;
  logic [GPIO_WIDTH-1:0] edge_q, edge_d;
  logic [GPIO_WIDTH-1:0] mask_q, mask_d;
  logic [GPIO_WIDTH-1:0] prev_q, prev_d;
  logic                  irq_q,  irq_d;
  logic [GPIO_WIDTH-1:0] w1c;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] in_val;
  logic [GPIO_WIDTH-1:0] sync_last;
  logic [GPIO_WIDTH-1:0] rd_val;

  // Upper address and data bits are not decoded.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.Address, bus.WriteData};

  assign wr_en     = bus.sel && bus.MemWrite;
  assign word_addr = bus.Address[4:2];
  assign wd        = bus.WriteData[GPIO_WIDTH-1:0];
  assign sync_last = sync_q[SYNC_STAGES-1];

  // Shift the pins into stage 0. Each stage takes the previous stage's value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], gpio_port_in};
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [GPIO_WIDTH-1:0]         in_q, in_d;
  logic [GPIO_WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  // A bit of IN follows the synchroniser only after the two have disagreed for
  // DB_CYCLES consecutive cycles. Any agreement, such as a bounce back, restarts the count.
  always_comb begin
    in_d  = in_q;
    cnt_d = cnt_q;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      if (sync_last[i] != in_q[i]) begin
        if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          in_d[i]  = sync_last[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q  <= '0;
      cnt_q <= '0;
    end else begin
      in_q  <= in_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_val = in_q;
`else
  // Without debounce, the last synchroniser stage is the IN register.
  localparam int unused_db_cycles = DB_CYCLES;
  assign in_val = sync_last;
`endif

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr_en) begin
      case (word_addr)
        A_OUT:   out_d  = wd;
        A_DIR:   dir_d  = wd;
        A_EDGE:  w1c    = wd;
        A_MASK:  mask_d = wd;
        A_SET:   out_d  = out_q | wd;
        A_CLR:   out_d  = out_q & ~wd;
        A_TGL:   out_d  = out_q ^ wd;
        default: ;
      endcase
    end
    rise   = in_val & ~prev_q;
    // A new rise overrides a W1C to the same bit in the same cycle.
    edge_d = (edge_q & ~w1c) | rise;
    prev_d = in_val;
    irq_d  = |(edge_q & mask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      out_q  <= '0;
      dir_q  <= '0;
      edge_q <= '0;
      mask_q <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      out_q  <= out_d;
      dir_q  <= dir_d;
      edge_q <= edge_d;
      mask_q <= mask_d;
      prev_q <= prev_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rd_val = '0;
    if (bus.sel) begin
      case (word_addr)
        A_OUT:   rd_val = out_q;
        A_IN:    rd_val = in_val;
        A_DIR:   rd_val = dir_q;
        A_EDGE:  rd_val = edge_q;
        A_MASK:  rd_val = mask_q;
        default: rd_val = '0;
      endcase
    end
  end

  assign bus.ReadData  = DATA_WIDTH'(rd_val);
  assign gpio_port_out = out_q & dir_q;
  assign gpio_oe       = dir_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_bank_mmio.sv
`timescale 1ns/1ps
// tb_gpio_bank_mmio: directed test of the GPIO bank's register map, pin path, edge/irq and reset.
// Latency: every expectation is counted in clk edges from the stimulus.
// Backpressure: none on this bus.
module tb_gpio_bank_mmio;

  localparam int DW = 32;
  localparam int GW = 8;
  localparam int SS = 2;
  localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SS + DB;
`else
  localparam int LAT = SS;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [GW-1:0] pins;
  logic [GW-1:0] gpio_port_out;
  logic [GW-1:0] gpio_oe;
  logic          irq;
  logic [31:0]   rdat;

  int total = 0;
  int bad   = 0;

  gpio_bank_mmio_if #(.DATA_WIDTH(DW)) bus_if ();

  gpio_bank_mmio #(
    .DATA_WIDTH (DW),
    .GPIO_WIDTH (GW),
    .SYNC_STAGES(SS),
    .DB_CYCLES  (DB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if.slave),
    .gpio_port_in (pins),
    .gpio_port_out(gpio_port_out),
    .gpio_oe      (gpio_oe),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step n rising edges, then settle 1 ns past the last one.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] data);
    bus_if.sel       = 1'b1;
    bus_if.MemWrite  = 1'b1;
    bus_if.Address   = {27'd0, idx, 2'b00};
    bus_if.WriteData = data;
    clk_n(1);
    bus_if.MemWrite  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    bus_if.sel      = 1'b1;
    bus_if.MemWrite = 1'b0;
    bus_if.Address  = {27'd0, idx, 2'b00};
    #1;
    rdat = bus_if.ReadData;
    chk(tag, rdat, exp);
  endtask

  initial begin
    reset            = 1'b1;
    pins             = '0;
    bus_if.sel       = 1'b0;
    bus_if.MemWrite  = 1'b0;
    bus_if.Address   = '0;
    bus_if.WriteData = '0;
    clk_n(3);
    chk("rst_out", 32'(gpio_port_out), 32'h0);
    chk("rst_oe",  32'(gpio_oe),       32'h0);
    chk("rst_irq", 32'(irq),           32'h0);
    reset = 1'b0;
    clk_n(1);

    // 1: all offsets read 0 after reset
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_rd%0d", a), 3'(a), 32'h0);

    // Writes without sel are ignored.
    bus_if.sel       = 1'b0;
    bus_if.MemWrite  = 1'b1;
    bus_if.Address   = '0;
    bus_if.WriteData = 32'h33;
    clk_n(1);
    bus_if.MemWrite  = 1'b0;
    rd_chk("nosel_wr", 3'd0, 32'h0);

    // 2: atomic ops. 0xA5 | 0x0A = 0xAF, & ~0x01 = 0xAE, ^ 0xF0 = 0x5E.
    wr(3'd2, 32'hFF);
    wr(3'd0, 32'hFFFF_FFA5);
    rd_chk("out_zext", 3'd0, 32'hA5);
    wr(3'd5, 32'h0A);
    rd_chk("set", 3'd0, 32'hAF);
    wr(3'd6, 32'h01);
    rd_chk("clr", 3'd0, 32'hAE);
    wr(3'd7, 32'hF0);
    rd_chk("tgl", 3'd0, 32'h5E);
    chk("pout_5e", 32'(gpio_port_out), 32'h5E);
    chk("oe_ff",   32'(gpio_oe),       32'hFF);
    bus_if.sel = 1'b0;
    #1;
    chk("rd_nosel", bus_if.ReadData, 32'h0);

    // 3: direction masking
    wr(3'd2, 32'h0F);
    wr(3'd0, 32'hFF);
    chk("pout_0f", 32'(gpio_port_out), 32'h0F);
    wr(3'd2, 32'h00);
    chk("pout_00", 32'(gpio_port_out), 32'h00);
    rd_chk("out_kept", 3'd0, 32'hFF);

    // 4: rise on pin 3, then masked irq, then W1C
    wr(3'd4, 32'h08);
    rd_chk("mask_rd", 3'd4, 32'h08);
    clk_n(1);
    pins = 8'h08;
    clk_n(LAT - 1);
    rd_chk("in_early", 3'd1, 32'h00);
    clk_n(1);
    rd_chk("in_3", 3'd1, 32'h08);
    rd_chk("edge_early", 3'd3, 32'h00);
    clk_n(1);
    rd_chk("edge_3", 3'd3, 32'h08);
    chk("irq_early", 32'(irq), 32'h0);
    clk_n(1);
    chk("irq_set", 32'(irq), 32'h1);
    wr(3'd3, 32'h08);
    rd_chk("edge_w1c", 3'd3, 32'h00);
    chk("irq_lag", 32'(irq), 32'h1);
    clk_n(1);
    chk("irq_clr", 32'(irq), 32'h0);

    // 5: a W1C that lands on the same edge as a new rise does not clear the bit.
    pins = 8'h00;
    clk_n(LAT + 2);
    pins = 8'h08;
    clk_n(LAT + 2);
    chk("irq_pre5", 32'(irq), 32'h1);
    pins = 8'h00;
    clk_n(LAT + 2);
    pins = 8'h08;
    clk_n(LAT);
    wr(3'd3, 32'h08);
    rd_chk("edge_setwins", 3'd3, 32'h08);
    clk_n(1);
    chk("irq_stays", 32'(irq), 32'h1);
    pins = 8'h00;
    clk_n(LAT + 2);
    wr(3'd3, 32'hFF);
    rd_chk("edge_cleared", 3'd3, 32'h00);

`ifdef GPIO_DEBOUNCE_EN
    // 6a: a 3-cycle glitch is shorter than the debounce window and is filtered out.
    pins = 8'h01;
    clk_n(3);
    pins = 8'h00;
    clk_n(LAT + 4);
    rd_chk("db_in", 3'd1, 32'h00);
    rd_chk("db_edge", 3'd3, 32'h00);
`endif

    // Pin 0 is held high, which sets EDGE to 0x01 and raises irq. Asserting reset then clears everything.
    wr(3'd2, 32'hFF);
    pins = 8'h01;
    clk_n(LAT + 1);
    rd_chk("edge_01", 3'd3, 32'h01);
    wr(3'd4, 32'h01);
    clk_n(1);
    chk("irq_01", 32'(irq), 32'h1);
    chk("pout_pre", 32'(gpio_port_out), 32'hFF);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_irq",  32'(irq),           32'h0);
    chk("arst_pout", 32'(gpio_port_out), 32'h0);
    chk("arst_oe",   32'(gpio_oe),       32'h0);
    rd_chk("arst_edge", 3'd3, 32'h00);
    clk_n(2);
    reset = 1'b0;
    // The pin is still high after release, so exactly one new edge event follows.
    clk_n(LAT);
    rd_chk("post_edge_early", 3'd3, 32'h00);
    clk_n(1);
    rd_chk("post_edge", 3'd3, 32'h01);
    rd_chk("post_mask", 3'd4, 32'h00);
    clk_n(2);
    chk("post_irq", 32'(irq), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
